// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase/timing checker for a two-direction traffic light
module traffic_light_monitor #(
    parameter int GREEN_CYCLES   = 30,
    parameter int YELLOW_CYCLES  = 5,
    parameter int RED_RED_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        red1,
    input  logic        yellow1,
    input  logic        green1,
    input  logic        red2,
    input  logic        yellow2,
    input  logic        green2,
    input  logic        clr_err,
    output logic        locked,
    output logic [2:0]  phase,
    output logic        phase_start,
    output logic        err_conflict,
    output logic        err_illegal,
    output logic        err_seq,
    output logic        err_time,
    output logic [15:0] rotations
);

    typedef enum logic [2:0] {C_RG, C_RY, C_RR, C_GR, C_YR, C_ILL, C_CON} cls_t;
    typedef enum logic {S_SYNC, S_TRACK} state_t;

    localparam logic [2:0]       P_UNK   = 3'd7;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    cls_t             cls;
    logic             locked_n, phase_start_n, partial, partial_n;
    logic [2:0]       phase_n, nxt;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [15:0]      rotations_n;
    logic             set_conflict, set_illegal, set_seq, set_time;
    logic             ok1, ok2;

    function automatic cls_t phase_cls(input logic [2:0] p);
        case (p)
            3'd0:    phase_cls = C_RG;
            3'd1:    phase_cls = C_RY;
            3'd2:    phase_cls = C_RR;
            3'd3:    phase_cls = C_GR;
            3'd4:    phase_cls = C_YR;
            3'd5:    phase_cls = C_RR;
            default: phase_cls = C_ILL;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] req(input logic [2:0] p);
        case (p)
            3'd0, 3'd3: req = CNT_W'(GREEN_CYCLES);
            3'd1, 3'd4: req = CNT_W'(YELLOW_CYCLES);
            default:    req = CNT_W'(RED_RED_CYCLES);
        endcase
    endfunction

    // RR is ambiguous on its own; the previous phase tells which half of the cycle we are in
    function automatic logic [2:0] cls_phase(input cls_t c, input logic [2:0] old);
        case (c)
            C_RG:    cls_phase = 3'd0;
            C_RY:    cls_phase = 3'd1;
            C_RR:    cls_phase = (old == 3'd0 || old == 3'd1) ? 3'd2 : 3'd5;
            C_GR:    cls_phase = 3'd3;
            C_YR:    cls_phase = 3'd4;
            default: cls_phase = P_UNK;
        endcase
    endfunction

    always_comb begin
        ok1 = (red1 ^ yellow1 ^ green1) & ~(red1 & yellow1 & green1);
        ok2 = (red2 ^ yellow2 ^ green2) & ~(red2 & yellow2 & green2);
        cls = C_YR;
        if (!ok1 || !ok2)          cls = C_ILL;
        else if (!red1 && !red2)   cls = C_CON;
        else if (red1 && red2)     cls = C_RR;
        else if (red1 && green2)   cls = C_RG;
        else if (red1)             cls = C_RY;
        else if (green1)           cls = C_GR;
    end

    assign nxt     = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_n       = state;
        locked_n      = locked;
        phase_n       = phase;
        phase_start_n = 1'b0;
        cnt_n         = cnt;
        partial_n     = partial;
        rotations_n   = rotations;
        set_conflict  = 1'b0;
        set_illegal   = 1'b0;
        set_seq       = 1'b0;
        set_time      = 1'b0;
        if (cls == C_ILL || cls == C_CON) begin
            set_illegal  = (cls == C_ILL);
            set_conflict = (cls == C_CON);
            state_n      = S_SYNC;
            locked_n     = 1'b0;
            phase_n      = P_UNK;
            cnt_n        = '0;
            partial_n    = 1'b0;
        end else if (state == S_SYNC) begin
            if (cls != C_RR) begin
                state_n   = S_TRACK;
                locked_n  = 1'b1;
                phase_n   = cls_phase(cls, phase);
                cnt_n     = CNT_ONE;
                partial_n = 1'b1;
            end
        end else if (cls == phase_cls(phase)) begin
            cnt_n = cnt_inc;
            // fires exactly once, on the edge the phase becomes one cycle too long
            if (!partial && cnt_inc == req(phase) + CNT_ONE)
                set_time = 1'b1;
        end else if (cls == phase_cls(nxt)) begin
            phase_n       = nxt;
            phase_start_n = 1'b1;
            cnt_n         = CNT_ONE;
            partial_n     = 1'b0;
            if (!partial && cnt < req(phase))
                set_time = 1'b1;
            if (phase == 3'd5)
                rotations_n = rotations + 16'd1;
        end else begin
            set_seq   = 1'b1;
            phase_n   = cls_phase(cls, phase);
            cnt_n     = CNT_ONE;
            partial_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SYNC;
            locked       <= 1'b0;
            phase        <= P_UNK;
            phase_start  <= 1'b0;
            cnt          <= '0;
            partial      <= 1'b0;
            rotations    <= '0;
            err_conflict <= 1'b0;
            err_illegal  <= 1'b0;
            err_seq      <= 1'b0;
            err_time     <= 1'b0;
        end else begin
            state        <= state_n;
            locked       <= locked_n;
            phase        <= phase_n;
            phase_start  <= phase_start_n;
            cnt          <= cnt_n;
            partial      <= partial_n;
            rotations    <= rotations_n;
            err_conflict <= (err_conflict & ~clr_err) | set_conflict;
            err_illegal  <= (err_illegal & ~clr_err) | set_illegal;
            err_seq      <= (err_seq & ~clr_err) | set_seq;
            err_time     <= (err_time & ~clr_err) | set_time;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed and randomized checks of traffic_light_monitor
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst_n, red1, yellow1, green1, red2, yellow2, green2, clr_err;
    logic        locked, phase_start, err_conflict, err_illegal, err_seq, err_time;
    logic [2:0]  phase;
    logic [15:0] rotations;

    traffic_light_monitor #(
        .GREEN_CYCLES(30), .YELLOW_CYCLES(5), .RED_RED_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .red1(red1), .yellow1(yellow1), .green1(green1),
        .red2(red2), .yellow2(yellow2), .green2(green2),
        .clr_err(clr_err), .locked(locked), .phase(phase), .phase_start(phase_start),
        .err_conflict(err_conflict), .err_illegal(err_illegal), .err_seq(err_seq),
        .err_time(err_time), .rotations(rotations)
    );

    always #5 clk = ~clk;

    localparam int RG = 0, RY = 1, RR = 2, GR = 3, YR = 4, ILL = 5, CON = 6;
    int P_CLS [6] = '{RG, RY, RR, GR, YR, RR};
    int P_DUR [6] = '{30, 5, 2, 30, 5, 2};

    int n_asserts = 0;
    int n_fail    = 0;

    int m_locked, m_phase, m_start, m_len, m_partial, m_rot;
    int m_econ, m_eill, m_eseq, m_etime;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
    function automatic logic [5:0] mk(input int c);
        case (c)
            RG:      mk = 6'b100_001;
            RY:      mk = 6'b100_010;
            RR:      mk = 6'b100_100;
            GR:      mk = 6'b001_100;
            default: mk = 6'b010_100;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] v);
        if ($countones(v[5:3]) != 1 || $countones(v[2:0]) != 1) return ILL;
        if (!v[5] && !v[2]) return CON;
        for (int c = 0; c < 5; c++)
            if (mk(c) == v) return c;
        return ILL;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_phase = 7; m_start = 0; m_len = 0; m_partial = 0; m_rot = 0;
        m_econ = 0; m_eill = 0; m_eseq = 0; m_etime = 0;
    endtask

    task automatic model_step(input logic [5:0] v, input logic clr);
        int c, nx;
        int s_con, s_ill, s_seq, s_time;
        c = classify(v);
        s_con = 0; s_ill = 0; s_seq = 0; s_time = 0;
        m_start = 0;
        nx = (m_phase + 1) % 6;
        if (c == ILL || c == CON) begin
            s_ill = (c == ILL); s_con = (c == CON);
            m_locked = 0; m_phase = 7; m_len = 0; m_partial = 0;
        end else if (!m_locked) begin
            if (c != RR) begin
                m_locked = 1; m_len = 1; m_partial = 1;
                for (int p = 5; p >= 0; p--) if (P_CLS[p] == c) m_phase = p;
            end
        end else if (c == P_CLS[m_phase]) begin
            m_len++;
            if (!m_partial && m_len == P_DUR[m_phase] + 1) s_time = 1;
        end else if (c == P_CLS[nx]) begin
            if (!m_partial && m_len < P_DUR[m_phase]) s_time = 1;
            if (m_phase == 5) m_rot = (m_rot + 1) % 65536;
            m_phase = nx; m_start = 1; m_len = 1; m_partial = 0;
        end else begin
            s_seq = 1;
            if (c == RR) m_phase = (m_phase < 2) ? 2 : 5;
            else for (int p = 5; p >= 0; p--) if (P_CLS[p] == c) m_phase = p;
            m_len = 1; m_partial = 1;
        end
        m_econ  = (m_econ  && !clr) || s_con;
        m_eill  = (m_eill  && !clr) || s_ill;
        m_eseq  = (m_eseq  && !clr) || s_seq;
        m_etime = (m_etime && !clr) || s_time;
    endtask

    task automatic check_model();
        chk("locked",       16'(locked),       16'(m_locked));
        chk("phase",        16'(phase),        16'(m_phase));
        chk("phase_start",  16'(phase_start),  16'(m_start));
        chk("err_conflict", 16'(err_conflict), 16'(m_econ));
        chk("err_illegal",  16'(err_illegal),  16'(m_eill));
        chk("err_seq",      16'(err_seq),      16'(m_eseq));
        chk("err_time",     16'(err_time),     16'(m_etime));
        chk("rotations",    rotations,         16'(m_rot));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_locked"}, 16'(locked), 16'd0);
        chk({tag, "_phase"},  16'(phase),  16'd7);
        chk({tag, "_start"},  16'(phase_start), 16'd0);
        chk({tag, "_errs"},   16'({err_conflict, err_illegal, err_seq, err_time}), 16'd0);
        chk({tag, "_rot"},    rotations, 16'd0);
    endtask

    task automatic step(input logic [5:0] v, input logic clr);
        {red1, yellow1, green1, red2, yellow2, green2} = v;
        clr_err = clr;
        @(posedge clk);
        model_step(v, clr);
        #1;
        check_model();
        clr_err = 1'b0;
    endtask

    task automatic run(input int c, input int n);
        for (int i = 0; i < n; i++) step(mk(c), 1'b0);
    endtask

    initial begin
        logic [5:0] v;
        int len, k;
        rst_n = 1'b0; clr_err = 1'b0;
        {red1, yellow1, green1, red2, yellow2, green2} = 6'b0;
        model_reset();
        #12;
        chk_reset("reset");
        rst_n = 1'b1;

        // nominal: two full rotations starting at RG
        step(mk(RG), 1'b0);
        chk("lock_first_edge", 16'(locked), 16'd1);
        run(RG, 29);
        for (int r = 0; r < 2; r++) begin
            run(RY, 5); run(RR, 2); run(GR, 30); run(YR, 5); run(RR, 2);
            step(mk(RG), 1'b0);
            chk("nom_phase_start", 16'(phase_start), 16'd1);
            if (r == 0) run(RG, 29);
        end
        chk("nom_rotations", rotations, 16'd2);
        chk("nom_errs", 16'({err_conflict, err_illegal, err_seq, err_time}), 16'd0);
        run(RG, 29);

        // long green
        run(RY, 5); run(RR, 2); run(GR, 30);
        chk("long_green_30", 16'(err_time), 16'd0);
        step(mk(GR), 1'b0);
        chk("long_green_31", 16'(err_time), 16'd1);
        step(mk(YR), 1'b0);
        chk("long_green_yr_phase", 16'(phase), 16'd4);
        chk("long_green_no_seq", 16'(err_seq), 16'd0);
        run(YR, 4); run(RR, 2);

        // clear without event, then skip straight to RR
        step(mk(RG), 1'b1);
        chk("clr_no_event", 16'({err_conflict, err_illegal, err_seq, err_time}), 16'd0);
        run(RG, 29);
        step(mk(RR), 1'b0);
        chk("skip_seq", 16'(err_seq), 16'd1);
        chk("skip_phase", 16'(phase), 16'd2);
        chk("skip_locked", 16'(locked), 16'd1);
        step(mk(RR), 1'b0);
        step(mk(GR), 1'b0);
        chk("skip_partial_no_time", 16'(err_time), 16'd0);
        run(GR, 29); run(YR, 4);
        step(mk(RR), 1'b0);
        chk("short_yellow", 16'(err_time), 16'd1);
        step(mk(RR), 1'b0);

        // conflict and illegal
        step(6'b001_001, 1'b0);
        chk("conf_flag", 16'(err_conflict), 16'd1);
        chk("conf_not_illegal", 16'(err_illegal), 16'd0);
        chk("conf_unlock", 16'(locked), 16'd0);
        chk("conf_phase", 16'(phase), 16'd7);
        step(6'b101_100, 1'b0);
        chk("illegal_flag", 16'(err_illegal), 16'd1);
        for (int i = 0; i < 3; i++) begin
            step(mk(RR), 1'b0);
            chk("rr_no_lock", 16'(locked), 16'd0);
        end
        step(mk(GR), 1'b0);
        chk("relock", 16'(locked), 16'd1);
        chk("relock_phase", 16'(phase), 16'd3);
        run(GR, 5);

        // clear behaviour
        step(mk(GR), 1'b1);
        chk("clr_all", 16'({err_conflict, err_illegal, err_seq, err_time}), 16'd0);
        step(6'b001_001, 1'b1);
        chk("clr_set_wins", 16'(err_conflict), 16'd1);

        // randomized rotations with jittered durations, skips, stray vectors and clears
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 6; p++) begin
                if ($urandom_range(0, 11) == 0) continue;
                len = P_DUR[p];
                k = $urandom_range(0, 5);
                if (k == 0) len = len - 1;
                else if (k == 1) len = len + 1;
                for (int i = 0; i < len; i++) begin
                    v = mk(P_CLS[p]);
                    if ($urandom_range(0, 60) == 0) v = 6'($urandom);
                    step(v, $urandom_range(0, 25) == 0);
                end
            end
        end

        // asynchronous reset in the middle of a green phase
        run(RY, 5); run(RR, 2); run(GR, 10);
        chk("pre_reset_rot_nonzero", 16'(rotations != 16'd0), 16'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        model_reset();
        #2;
        rst_n = 1'b1;
        step(mk(GR), 1'b0);
        chk("post_reset_lock", 16'(locked), 16'd1);
        run(GR, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
